// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: round-robin shared "1001" serial detector for two word requesters.
module seq_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [WORD_W-1:0] req_data0,
    input  logic [WORD_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [CNT_W-1:0]  resp_count,
    output logic              resp_hit,
    output logic              busy,
    output logic              det_bit,
    output logic              det_match
);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;
    typedef enum logic [1:0] {D0, D1, D2, D3} det_t;
    st_t               st_q;
    det_t              det_q, det_d;
    logic [WORD_W-1:0] sh_q;
    logic [BW-1:0]     bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              id_q, rr_q;
    logic [1:0]        gnt;
    logic              acc_id;
    // Contention goes to whichever requester was not served last.
    assign gnt        = (&req_valid) ? (rr_q ? 2'b01 : 2'b10) : req_valid;
    assign req_ready  = (st_q == IDLE) ? gnt : 2'b00;
    assign acc_id     = req_ready[1];
    assign busy       = (st_q != IDLE);
    assign det_bit    = (st_q == SHIFT) & sh_q[WORD_W-1];
    assign det_match  = (st_q == SHIFT) & (det_q == D3) & det_bit;
    assign resp_valid = (st_q == DONE);
    assign resp_id    = resp_valid & id_q;
    assign resp_count = resp_valid ? cnt_q : '0;
    assign resp_hit   = |resp_count;
    always_comb det_d = det_bit ? D1 : (det_q == D1) ? D2 : (det_q == D2) ? D3 : D0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= IDLE;
            det_q <= D0;
            sh_q  <= '0;
            bit_q <= '0;
            cnt_q <= '0;
            id_q  <= 1'b0;
            rr_q  <= 1'b1;
        end else begin
            case (st_q)
                IDLE: if (|req_ready) begin
                    sh_q  <= acc_id ? req_data1 : req_data0;
                    id_q  <= acc_id;
                    rr_q  <= acc_id;
                    cnt_q <= '0;
                    det_q <= D0;
                    bit_q <= '0;
                    st_q  <= SHIFT;
                end
                SHIFT: begin
                    sh_q  <= sh_q << 1;
                    det_q <= det_d;
                    bit_q <= bit_q + 1'b1;
                    if (det_match && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (bit_q == BW'(WORD_W - 1)) st_q <= DONE;
                end
                DONE: if (resp_ready) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed scenario bench for seq_scan_ctrl (WORD_W=8, CNT_W=4).
module tb_seq_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;
    logic       resp_ready = 1'b0;
    logic [1:0] req_ready;
    logic       resp_valid, resp_id, resp_hit, busy, det_bit, det_match;
    logic [3:0] resp_count;
    int total = 0;
    int bad = 0;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_count(resp_count),
        .resp_hit(resp_hit), .busy(busy), .det_bit(det_bit), .det_match(det_match)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Present a request, sample the grant, clock the accept, drop the served valid.
    task start_job(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, output logic [1:0] g);
        req_valid = v;
        req_data0 = d0;
        req_data1 = d1;
        #1;
        g = req_ready;
        tick;
        req_valid = req_valid & ~g;
    endtask

    // From shift cycle 1, record det_match per shift cycle and the cycles until resp_valid.
    task shift_obs(output logic [7:0] mm, output int lat);
        mm = 8'h00;
        lat = 1;
        while (!resp_valid && lat < 30) begin
            if (lat <= 8) mm[lat-1] = det_match;
            tick;
            lat++;
        end
    endtask

    task finish_resp;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task test_reset;
        logic [10:0] o;
        reset = 1'b1;
        tick;
        o = {req_ready, resp_valid, resp_id, resp_count, resp_hit, busy, det_bit};
        total++;
        if (o !== 11'd0 || det_match !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b det_match=%b exp=0", o, det_match);
        end
        reset = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b resp_valid=%b exp=0/0", busy, resp_valid);
        end
    endtask

    task test_single;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        start_job(2'b01, 8'b1001_0000, 8'h00, g);
        total++;
        if (g !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", g); end
        total++;
        if (req_ready !== 2'b00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_shift_ready req_ready=%b busy=%b exp=00/1", req_ready, busy);
        end
        shift_obs(mm, lat);
        total++;
        if (lat !== 9) begin bad++; $display("FAIL single_latency got=%0d exp=9", lat); end
        total++;
        if (mm !== 8'b0000_1000) begin bad++; $display("FAIL single_match_pulses got=%b exp=00001000", mm); end
        total++;
        if ({resp_id, resp_count, resp_hit} !== {1'b0, 4'd1, 1'b1}) begin
            bad++;
            $display("FAIL single_resp id=%b count=%0d hit=%b exp=0/1/1", resp_id, resp_count, resp_hit);
        end
        finish_resp;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release resp_valid=%b busy=%b exp=0/0", resp_valid, busy);
        end
    endtask

    task test_overlap;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        start_job(2'b10, 8'h00, 8'b1001_0010, g);
        total++;
        if (g !== 2'b10) begin bad++; $display("FAIL overlap_grant got=%b exp=10", g); end
        shift_obs(mm, lat);
        total++;
        if (mm !== 8'b0100_1000) begin bad++; $display("FAIL overlap_match_pulses got=%b exp=01001000", mm); end
        total++;
        if ({resp_id, resp_count, resp_hit} !== {1'b1, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL overlap_resp id=%b count=%0d hit=%b exp=1/2/1", resp_id, resp_count, resp_hit);
        end
        finish_resp;
    endtask

    task test_round_robin;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        do_reset;
        start_job(2'b11, 8'b1001_1001, 8'b0000_0000, g);
        total++;
        if (g !== 2'b01) begin bad++; $display("FAIL rr_first_grant got=%b exp=01", g); end
        shift_obs(mm, lat);
        total++;
        if (resp_id !== 1'b0 || resp_count !== 4'd2) begin
            bad++;
            $display("FAIL rr_first_resp id=%b count=%0d exp=0/2", resp_id, resp_count);
        end
        finish_resp;
        start_job(req_valid, 8'h00, 8'b0000_0000, g);
        total++;
        if (g !== 2'b10) begin bad++; $display("FAIL rr_second_grant got=%b exp=10", g); end
        shift_obs(mm, lat);
        total++;
        if (resp_id !== 1'b1 || resp_count !== 4'd0 || resp_hit !== 1'b0) begin
            bad++;
            $display("FAIL rr_second_resp id=%b count=%0d hit=%b exp=1/0/0", resp_id, resp_count, resp_hit);
        end
        finish_resp;
        start_job(2'b11, 8'b1001_0000, 8'b1001_0010, g);
        total++;
        if (g !== 2'b01) begin bad++; $display("FAIL rr_third_grant got=%b exp=01", g); end
        shift_obs(mm, lat);
        total++;
        if (resp_id !== 1'b0 || resp_count !== 4'd1) begin
            bad++;
            $display("FAIL rr_third_resp id=%b count=%0d exp=0/1", resp_id, resp_count);
        end
        finish_resp;
        req_valid = 2'b00;
        tick;
    endtask

    task test_no_carry;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        start_job(2'b01, 8'b0000_0100, 8'h00, g);
        shift_obs(mm, lat);
        total++;
        if (resp_count !== 4'd0 || resp_hit !== 1'b0) begin
            bad++;
            $display("FAIL nocarry_first count=%0d hit=%b exp=0/0", resp_count, resp_hit);
        end
        finish_resp;
        start_job(2'b01, 8'b1000_0000, 8'h00, g);
        shift_obs(mm, lat);
        total++;
        if (resp_count !== 4'd0 || resp_hit !== 1'b0 || mm !== 8'h00) begin
            bad++;
            $display("FAIL nocarry_second count=%0d hit=%b pulses=%b exp=0/0/00000000", resp_count, resp_hit, mm);
        end
        finish_resp;
    endtask

    task test_backpressure;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        start_job(2'b01, 8'b1001_0000, 8'h00, g);
        shift_obs(mm, lat);
        req_valid = 2'b10;
        req_data1 = 8'b1001_0010;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({resp_valid, resp_id, resp_count, req_ready} !== {1'b1, 1'b0, 4'd1, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold_%0d valid=%b id=%b count=%0d req_ready=%b exp=1/0/1/00",
                         k, resp_valid, resp_id, resp_count, req_ready);
            end
            tick;
        end
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        total++;
        if (req_ready !== 2'b10 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_pending_grant req_ready=%b resp_valid=%b exp=10/0", req_ready, resp_valid);
        end
        tick;
        req_valid = 2'b00;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL bp_pending_accept busy=%b exp=1", busy); end
        shift_obs(mm, lat);
        total++;
        if (resp_id !== 1'b1 || resp_count !== 4'd2 || lat !== 9) begin
            bad++;
            $display("FAIL bp_pending_resp id=%b count=%0d lat=%0d exp=1/2/9", resp_id, resp_count, lat);
        end
        finish_resp;
    endtask

    task test_reset_mid;
        logic [1:0] g;
        logic [7:0] mm;
        int lat;
        int seen;
        start_job(2'b01, 8'b1001_1001, 8'h00, g);
        tick;
        tick;
        reset = 1'b1;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_id, resp_count, resp_hit, busy, det_bit, det_match} !== 12'd0) begin
            bad++;
            $display("FAIL midreset_outputs busy=%b det_bit=%b resp_valid=%b exp=0", busy, det_bit, resp_valid);
        end
        tick;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            seen += (resp_valid | busy) ? 1 : 0;
            tick;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midreset_no_resp active_cycles=%0d exp=0", seen); end
        start_job(2'b01, 8'b1001_1001, 8'h00, g);
        shift_obs(mm, lat);
        total++;
        if (resp_count !== 4'd2 || lat !== 9 || mm !== 8'b1000_1000) begin
            bad++;
            $display("FAIL midreset_rerun count=%0d lat=%0d pulses=%b exp=2/9/10001000", resp_count, lat, mm);
        end
        finish_resp;
    endtask

    initial begin
        test_reset;
        test_single;
        test_overlap;
        test_round_robin;
        test_no_carry;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Shared-resource controller for one serial "1001" pattern detector.
- Two requesters each submit a WORD_W-bit word over a valid/ready handshake. A round-robin arbiter grants one requester at a time.
- The granted word is serialized MSB-first through the internal overlapping 1001 detector. The match count is returned on a response handshake tagged with the requester id.
- Sits between parallel producers (e.g. a UART RX or register file) and the serial pattern-detection function.

Parameters:
- WORD_W, 8, bits per submitted word; legal range 4..16.
- CNT_W, 4, width of the match counter. Must satisfy 2^CNT_W > WORD_W/3.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester word-valid; bit i belongs to requester i.
- req_data0  input  WORD_W  word from requester 0.
- req_data1  input  WORD_W  word from requester 1.
- req_ready  output  2  one-hot accept; high only in IDLE, on the granted requester's bit.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  requester whose word produced the result.
- resp_count  output  CNT_W  number of 1001 matches in the word.
- resp_hit  output  1  resp_count != 0.
- busy  output  1  high in SHIFT and DONE.
- det_bit  output  1  serial bit currently fed to the detector (debug).
- det_match  output  1  single-cycle pulse when the detector completes a 1001 (debug).

Behaviour:
- Clock/reset: clk is the clock; reset is asynchronous and active-high.
- Reset values:
  - Controller state = IDLE; detector state = D0; counter = 0; shift register = 0.
  - rr_last = 1, so requester 0 has priority first.
  - All outputs 0.
- Controller FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE:
    - If exactly one req_valid bit is set, grant it.
    - If both are set, grant the requester that is not rr_last.
    - req_ready = one-hot grant, combinational from req_valid and rr_last; 0 outside IDLE.
    - On the handshake (req_valid[i] & req_ready[i]): latch the word into the shift register, latch id, set rr_last = i, clear the counter, reset the detector to D0, go to SHIFT.
  - SHIFT:
    - Runs exactly WORD_W cycles; the bit counter runs 0..WORD_W-1.
    - Each cycle: det_bit = shift register MSB; shift left by one; step the detector.
    - After bit WORD_W-1, go to DONE.
    - Requests are ignored (req_ready = 0).
  - DONE:
    - resp_valid = 1; resp_id, resp_count and resp_hit are held stable.
    - On resp_valid & resp_ready: go to IDLE. resp_valid drops the next cycle.
    - A new accept can occur in the first IDLE cycle after the response handshake.
- Detector, Mealy, overlapping, registered state. States: D0 (none), D1 ("1"), D2 ("10"), D3 ("100").
  - D0: 1 -> D1; 0 -> D0.
  - D1: 1 -> D1; 0 -> D2.
  - D2: 1 -> D1; 0 -> D3.
  - D3: 1 -> D1 with match; 0 -> D0.
  - det_match = (state == D3) & det_bit & in SHIFT.
  - On each match the counter increments. It saturates at 2^CNT_W-1 and never wraps.
- No pattern carries across words: the detector is forced to D0 at each accept.
- Latency: accept at edge t, then SHIFT during cycles t+1..t+WORD_W, then resp_valid high from cycle t+WORD_W+1.
- Simultaneous events:
  - A new req_valid during SHIFT or DONE waits; it is not lost provided the requester holds valid.
  - Requesters may drop req_valid before grant without side effects.
- Reset mid-operation (SHIFT or DONE): the job is aborted with no response; the block returns to reset values immediately.

Test Plan:
- Req0 only, data 8'b1001_0000 -> req_ready=2'b01 for 1 cycle; resp_valid 9 cycles after accept; resp_id=0, resp_count=1, resp_hit=1; one det_match pulse on the 4th shift cycle.
- Overlap, req1 data 8'b1001_0010 -> det_match on shift cycles 4 and 7; resp_count=2, resp_id=1.
- Both req_valid high with distinct words after reset -> req0 served first, then req1. Both high again -> req0 (rr_last=1). Order of resp_id: 0, 1, 0.
- No carry-over: word 8'b0000_0100 then word 8'b1000_0000 -> both resp_count=0, resp_hit=0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, resp_id and resp_count are stable; req_ready=0 throughout; the accept of the pending request happens the cycle after resp_ready=1.
- Assert reset on shift cycle 3 of data 8'b1001_1001 -> all outputs 0 next cycle and no response. A subsequent request with 8'b1001_1001 -> resp_count=2.
